// File: rtl/ir_nec_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ir_nec_pkg
// Description : Shared types and timing windows for the NEC IR receiver.
//               Window limits are inclusive and expressed in width ticks.
// Revision    : 1.0 - initial release
// ============================================================================
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5,
        RPT_STOP   = 3'd6
    } nec_state_t;

    localparam int NEC_BITS = 32;

    localparam logic [11:0] c_LEAD_MARK_MIN  = 12'd800;
    localparam logic [11:0] c_LEAD_MARK_MAX  = 12'd1000;
    localparam logic [11:0] c_LEAD_SPACE_MIN = 12'd400;
    localparam logic [11:0] c_LEAD_SPACE_MAX = 12'd500;
    localparam logic [11:0] c_RPT_SPACE_MIN  = 12'd190;
    localparam logic [11:0] c_RPT_SPACE_MAX  = 12'd260;
    localparam logic [11:0] c_BIT_MARK_MIN   = 12'd40;
    localparam logic [11:0] c_BIT_MARK_MAX   = 12'd75;
    localparam logic [11:0] c_ZERO_SPACE_MIN = 12'd40;
    localparam logic [11:0] c_ZERO_SPACE_MAX = 12'd75;
    localparam logic [11:0] c_ONE_SPACE_MIN  = 12'd140;
    localparam logic [11:0] c_ONE_SPACE_MAX  = 12'd190;

    function automatic logic in_win(input logic [11:0] w,
                                    input logic [11:0] lo,
                                    input logic [11:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_nec_rx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ir_nec_rx_if
// Description : Decoded-frame bus from the NEC receiver to game control.
//               addr/cmd : last valid frame; valid/rpt/err : 1-cycle strobes.
//               master = receiver side, slave = consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ir_nec_rx_if;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        valid;
    logic        rpt;
    logic        err;

    modport master (output addr, cmd, valid, rpt, err);
    modport slave  (input  addr, cmd, valid, rpt, err);
endinterface
`default_nettype wire

// File: rtl/ir_pulse_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ir_pulse_timer
// Description : Line conditioning and width measurement for the IR input.
//               2-FF synchronizer, polarity normalisation (mark=1), edge
//               detect, free-running tick divider, saturating width counter.
//   clk, reset : system clock, synchronous active-high reset
//   ir_in      : raw demodulated IR line (asynchronous)
//   mark       : normalised line level, 1 = mark
//   mark_rise  : mark started (1 cycle)
//   mark_fall  : mark ended (1 cycle)
//   width      : ticks since the last edge, saturating at 4095
// Revision    : 1.0 - initial release
// ============================================================================
module ir_pulse_timer #(
    parameter int FCLK          = 50_000_000,
    parameter int TICK_HZ       = 100_000,
    parameter int IR_ACTIVE_LOW = 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        ir_in,
    output logic             mark,
    output logic             mark_rise,
    output logic             mark_fall,
    output logic [11:0]      width
);

    localparam int          c_DIV      = FCLK / TICK_HZ;
    localparam int          c_DIV_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    // Raw line level while no mark is present.
    localparam logic        c_IDLE_LVL = (IR_ACTIVE_LOW != 0);

    logic [1:0]         r_sync;
    logic               r_mark_d;
    logic [c_DIV_W-1:0] r_div;
    logic [11:0]        r_width;
    logic               w_mark;
    logic               w_tick;
    logic               w_edge;

    assign w_mark    = r_sync[1] ^ c_IDLE_LVL;
    assign w_tick    = (r_div == c_DIV_LAST);
    assign w_edge    = w_mark ^ r_mark_d;

    assign mark      = w_mark;
    assign mark_rise = w_mark & ~r_mark_d;
    assign mark_fall = ~w_mark & r_mark_d;
    assign width     = r_width;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= {2{c_IDLE_LVL}};
            r_mark_d <= 1'b0;
            r_div    <= '0;
            r_width  <= '0;
        end else begin
            r_sync   <= {r_sync[0], ir_in};
            r_mark_d <= w_mark;
            r_div    <= w_tick ? '0 : r_div + c_DIV_W'(1);
            // A tick landing on the edge cycle belongs to the new phase, so a
            // phase of N tick periods always reads back as exactly N.
            if (w_edge) begin
                r_width <= {11'd0, w_tick};
            end else if (w_tick && (r_width != 12'hFFF)) begin
                r_width <= r_width + 12'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ir_nec_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ir_nec_rx
// Description : NEC infrared receiver. Decodes leader, 32 LSB-first data bits,
//               stop mark and repeat codes from a demodulated IR line.
//   clk, reset : system clock, synchronous active-high reset
//   ir_in      : raw demodulated IR line (asynchronous)
//   nec        : addr/cmd of last valid frame, valid/rpt/err strobes
// Revision    : 1.0 - initial release
// ============================================================================
module ir_nec_rx
    import ir_nec_pkg::*;
#(
    parameter int FCLK          = 50_000_000,
    parameter int TICK_HZ       = 100_000,
    parameter int IR_ACTIVE_LOW = 1,
    parameter int EXT_ADDR      = 0
) (
    input  wire logic   clk,
    input  wire logic   reset,
    input  wire logic   ir_in,
    ir_nec_rx_if.master nec
);

    logic        w_mark, w_mark_rise, w_mark_fall;
    logic [11:0] w_width;

    ir_pulse_timer #(
        .FCLK          (FCLK),
        .TICK_HZ       (TICK_HZ),
        .IR_ACTIVE_LOW (IR_ACTIVE_LOW)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .ir_in     (ir_in),
        .mark      (w_mark),
        .mark_rise (w_mark_rise),
        .mark_fall (w_mark_fall),
        .width     (w_width)
    );

    nec_state_t  r_state, w_state_nxt;
    logic [31:0] r_shift, w_shift_nxt;
    logic [5:0]  r_bitcnt, w_bitcnt_nxt;
    logic        r_have_frame, w_have_nxt;
    logic [15:0] r_addr, w_addr_nxt;
    logic [7:0]  r_cmd, w_cmd_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_rpt, w_rpt_nxt;
    logic        r_err, w_err_nxt;

    logic        w_fail;
    logic        w_frame_ok;
    logic        w_zero, w_one, w_bit_mark_ok;
    logic [5:0]  w_bitcnt_inc;

    // Bytes: [7:0] addr, [15:8] addr inverse (or high addr), [23:16] cmd,
    // [31:24] cmd inverse.
    assign w_frame_ok    = (r_shift[31:24] == ~r_shift[23:16]) &&
                           ((EXT_ADDR != 0) || (r_shift[15:8] == ~r_shift[7:0]));
    assign w_zero        = in_win(w_width, c_ZERO_SPACE_MIN, c_ZERO_SPACE_MAX);
    assign w_one         = in_win(w_width, c_ONE_SPACE_MIN, c_ONE_SPACE_MAX);
    assign w_bit_mark_ok = in_win(w_width, c_BIT_MARK_MIN, c_BIT_MARK_MAX);
    assign w_bitcnt_inc  = r_bitcnt + 6'd1;

    // Edges take priority over timeouts; space-phase timeouts are only judged
    // while the line is actually at space.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_have_nxt   = r_have_frame;
        w_addr_nxt   = r_addr;
        w_cmd_nxt    = r_cmd;
        w_valid_nxt  = 1'b0;
        w_rpt_nxt    = 1'b0;
        w_err_nxt    = 1'b0;
        w_fail       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_mark_rise) w_state_nxt = LEAD_MARK;
            end
            LEAD_MARK: begin
                if (w_mark_fall) begin
                    if (in_win(w_width, c_LEAD_MARK_MIN, c_LEAD_MARK_MAX))
                        w_state_nxt = LEAD_SPACE;
                    else
                        w_fail = 1'b1;
                end else if (w_width > c_LEAD_MARK_MAX) begin
                    w_fail = 1'b1;
                end
            end
            LEAD_SPACE: begin
                if (w_mark_rise) begin
                    if (in_win(w_width, c_LEAD_SPACE_MIN, c_LEAD_SPACE_MAX)) begin
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = BIT_MARK;
                    end else if (in_win(w_width, c_RPT_SPACE_MIN, c_RPT_SPACE_MAX)) begin
                        w_state_nxt  = RPT_STOP;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (!w_mark && (w_width > c_LEAD_SPACE_MAX)) begin
                    w_fail = 1'b1;
                end
            end
            BIT_MARK: begin
                if (w_mark_fall) begin
                    if (w_bit_mark_ok) w_state_nxt = BIT_SPACE;
                    else               w_fail = 1'b1;
                end else if (w_width > c_BIT_MARK_MAX) begin
                    w_fail = 1'b1;
                end
            end
            BIT_SPACE: begin
                if (w_mark_rise) begin
                    if (w_zero || w_one) begin
                        w_shift_nxt  = {w_one, r_shift[31:1]};
                        w_bitcnt_nxt = w_bitcnt_inc;
                        w_state_nxt  = (w_bitcnt_inc == 6'(NEC_BITS)) ? STOP_MARK : BIT_MARK;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (!w_mark && (w_width > c_ONE_SPACE_MAX)) begin
                    w_fail = 1'b1;
                end
            end
            STOP_MARK: begin
                if (w_mark_fall) begin
                    if (w_bit_mark_ok && w_frame_ok) begin
                        w_addr_nxt  = r_shift[15:0];
                        w_cmd_nxt   = r_shift[23:16];
                        w_valid_nxt = 1'b1;
                        w_have_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (w_width > c_BIT_MARK_MAX) begin
                    w_fail = 1'b1;
                end
            end
            RPT_STOP: begin
                if (w_mark_fall) begin
                    if (w_bit_mark_ok) begin
                        w_rpt_nxt   = r_have_frame;
                        w_state_nxt = IDLE;
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (w_width > c_BIT_MARK_MAX) begin
                    w_fail = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Any error forgets the last frame so a stray repeat cannot replay it.
        if (w_fail) begin
            w_err_nxt   = 1'b1;
            w_have_nxt  = 1'b0;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_have_frame <= 1'b0;
            r_addr       <= '0;
            r_cmd        <= '0;
            r_valid      <= 1'b0;
            r_rpt        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_have_frame <= w_have_nxt;
            r_addr       <= w_addr_nxt;
            r_cmd        <= w_cmd_nxt;
            r_valid      <= w_valid_nxt;
            r_rpt        <= w_rpt_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign nec.addr  = r_addr;
    assign nec.cmd   = r_cmd;
    assign nec.valid = r_valid;
    assign nec.rpt   = r_rpt;
    assign nec.err   = r_err;

endmodule
`default_nettype wire

// File: doc/ir_nec_rx.md
Name: ir_nec_rx

Overview:
- NEC infrared receiver/decoder. The counterpart of the NEC carrier/transmit path.
- Input is the demodulated output of an IR receiver module (carrier already stripped). The line is asynchronous and active-low by default.
- Measures mark/space widths with a coarse tick counter. Decodes leader, 32 data bits LSB-first, stop mark and repeat codes.
- Presents address/command with single-cycle strobes to the game control logic, where they act as snake direction inputs.

Parameters:
- FCLK, 50_000_000: clk frequency in Hz.
- TICK_HZ, 100_000: width-measurement tick rate (10 us resolution). Tick divisor is FCLK/TICK_HZ, integer, at least 2.
- IR_ACTIVE_LOW, 1: 1 means ir_in low denotes a mark.
- EXT_ADDR, 0: 1 skips the address-inverse check (extended NEC 16-bit address).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ir_in  in  1  raw demodulated IR line, asynchronous to clk
- addr  out  16  {byte1, byte0} of last valid frame
- cmd  out  8  command byte of last valid frame
- valid  out  1  one-cycle strobe; new addr/cmd loaded on the same cycle
- rpt  out  1  one-cycle strobe; repeat code received after a valid frame
- err  out  1  one-cycle strobe; malformed frame or timeout

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset clears addr=0, cmd=0, valid=0, rpt=0, err=0, state=IDLE, width=0, bit count=0, have_frame=0, and the synchronizer to the idle (space) level.
- Input conditioning:
  - 2-FF synchronizer, then polarity normalisation to mark=1.
  - Edge detect on the normalised signal. Edge-to-decision latency is 3 clk.
- Tick/width counting:
  - Tick divisor counter free-runs.
  - width is 12 bits, in ticks. It clears on every mark/space edge, increments on each tick, and saturates at 4095.
- Width windows, in ticks, inclusive:
  - LEAD_MARK 800..1000
  - LEAD_SPACE 400..500
  - RPT_SPACE 190..260
  - BIT_MARK 40..75
  - ZERO_SPACE 40..75
  - ONE_SPACE 140..190
- FSM states:
  - IDLE: mark start goes to LEAD_MARK.
  - LEAD_MARK: on mark end, width in window goes to LEAD_SPACE; otherwise err and IDLE.
  - LEAD_SPACE: on mark start, LEAD_SPACE window clears bitcnt and goes to BIT_MARK. RPT_SPACE window goes to RPT_STOP. Otherwise err and IDLE.
  - BIT_MARK: on mark end, BIT_MARK window goes to BIT_SPACE; otherwise err.
  - BIT_SPACE: on mark start, ZERO/ONE window shifts 0/1 into bit 31 of the shift register (LSB-first) and increments bitcnt. At bitcnt=32 go to STOP_MARK, else BIT_MARK. Otherwise err.
  - STOP_MARK: on mark end with BIT_MARK window, check the frame:
    - byte3 == ~byte2 is required.
    - byte1 == ~byte0 is required unless EXT_ADDR.
    - On pass: load addr/cmd, assert valid, set have_frame.
    - On fail: err, have_frame=0. Either way go to IDLE.
  - RPT_STOP: on mark end with BIT_MARK window, assert rpt if have_frame, else nothing. Go to IDLE. Bad width gives err.
- Timeout: in any non-IDLE state, width exceeding that phase's max window gives err, clears have_frame and goes to IDLE.
  - LEAD_SPACE timeout uses the 500 max.
  - BIT_SPACE timeout uses the 190 max.
- Priority: a timeout and an edge in the same cycle resolve to the edge. Strobes are mutually exclusive and never exceed one cycle.
- A mark appearing while in IDLE after err restarts cleanly. A noise glitch shorter than 40 ticks in a mark-end check errors out, never valid.
- Reset mid-frame: outputs return to reset values next cycle, and no strobe fires for the partial frame.
- addr/cmd hold their values until the next valid frame. They are unchanged by rpt or err.

Decomposition:
- Package ir_nec_pkg:
  - state enum nec_state_t {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_STOP}.
  - window localparams in ticks.
  - NEC_BITS=32.
- Sub-module ir_pulse_timer: synchronizer, polarity, edge detect, tick divider and saturating width counter. Outputs mark, mark_rise, mark_fall and width[11:0].
- The top holds the FSM, shift register and output registers.

Test Plan:
- Use FCLK=1_000_000 (10 clk per tick). Drive frame addr 0x00, cmd 0x45 with exact nominal timings -> one valid pulse, addr=0xFF00, cmd=0x45, err=0 throughout.
- The same frame, followed 40 ms later by a repeat code (9000 us mark, 2250 us space, 562 us mark) -> one rpt pulse, with addr/cmd unchanged. A repeat code after reset with no prior frame produces no rpt and no err.
- Frame with cmd inverse byte corrupted (0x45, 0xBB) -> err pulse, no valid, addr/cmd keep previous values, and a following repeat yields no rpt.
- Timing edges: bit spaces at 400/750 us and 1400/1900 us decode correctly. A 1000 us space gives err. A leader mark of 7000 us gives err.
- Line held idle mid-frame after bit 10 -> err within 1900 us plus 3 clk, state IDLE. A subsequent full frame decodes to valid.
- Assert reset mid-frame at bit 20, then release and send a frame with EXT_ADDR=1, addr 0x1234, cmd 0x08 -> no strobes before release, then valid with addr=0x1234, cmd=0x08.
